// File: rtl/fft_bank_pkg.sv
// Shared types and defaults for the FFT ping-pong sample memory.
// Holds default widths, the swap-state enum and the complex-word struct.
package fft_bank_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      SWAP
   } swap_st_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] re;
      logic [DATA_W_DEF-1:0] im;
   } cplx_t;

endpackage

// File: rtl/fft_cplx_dpram.sv
// Read-first true-dual-port complex RAM (real + imaginary planes).
// Ports A/B: en, we, addr, din_r/_i in; registered dout_r/_i out.
module fft_cplx_dpram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_din_r,
   input  logic [DATA_W-1:0] a_din_i,
   output logic [DATA_W-1:0] a_dout_r,
   output logic [DATA_W-1:0] a_dout_i,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_din_r,
   input  logic [DATA_W-1:0] b_din_i,
   output logic [DATA_W-1:0] b_dout_r,
   output logic [DATA_W-1:0] b_dout_i
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [2*DATA_W-1:0] mem [DEPTH];
   logic [2*DATA_W-1:0] a_q;
   logic [2*DATA_W-1:0] b_q;

   // A is written last so it wins a same-address write.
   always_ff @(posedge clock) begin
      if (b_en && b_we)
         mem[b_addr] <= {b_din_r, b_din_i};
      if (a_en && a_we)
         mem[a_addr] <= {a_din_r, a_din_i};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (a_en && !a_we)
            a_q <= mem[a_addr];
         if (b_en && !b_we)
            b_q <= mem[b_addr];
      end
   end

   assign a_dout_r = a_q[2*DATA_W-1:DATA_W];
   assign a_dout_i = a_q[DATA_W-1:0];
   assign b_dout_r = b_q[2*DATA_W-1:DATA_W];
   assign b_dout_i = b_q[DATA_W-1:0];

endmodule

// File: rtl/fft_pingpong_bank.sv
// Double-buffered complex FFT sample memory with swap handshake.
// Compute ports A/B own bank active_bank; the I/O port owns the other.
module fft_pingpong_bank
   import fft_bank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              swap_req,
   output logic              swap_busy,
   output logic              swap_ack,
   output logic              active_bank,
   input  logic              cmp_a_en,
   input  logic              cmp_a_we,
   input  logic [ADDR_W-1:0] cmp_a_addr,
   input  logic [DATA_W-1:0] cmp_a_din_r,
   input  logic [DATA_W-1:0] cmp_a_din_i,
   output logic [DATA_W-1:0] cmp_a_dout_r,
   output logic [DATA_W-1:0] cmp_a_dout_i,
   input  logic              cmp_b_en,
   input  logic              cmp_b_we,
   input  logic [ADDR_W-1:0] cmp_b_addr,
   input  logic [DATA_W-1:0] cmp_b_din_r,
   input  logic [DATA_W-1:0] cmp_b_din_i,
   output logic [DATA_W-1:0] cmp_b_dout_r,
   output logic [DATA_W-1:0] cmp_b_dout_i,
   input  logic              io_en,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_din_r,
   input  logic [DATA_W-1:0] io_din_i,
   output logic [DATA_W-1:0] io_dout_r,
   output logic [DATA_W-1:0] io_dout_i,
   output logic              io_dout_valid,
   output logic              collision
);

   swap_st_t state, state_n;
   logic     idle;
   logic     io_bank;

   logic              pa_en   [2];
   logic              pa_we   [2];
   logic [ADDR_W-1:0] pa_addr [2];
   logic [DATA_W-1:0] pa_dr   [2];
   logic [DATA_W-1:0] pa_di   [2];
   logic              pb_en   [2];
   logic              pb_we   [2];
   logic [ADDR_W-1:0] pb_addr [2];
   logic [DATA_W-1:0] pb_dr   [2];
   logic [DATA_W-1:0] pb_di   [2];
   logic [DATA_W-1:0] qa_r    [2];
   logic [DATA_W-1:0] qa_i    [2];
   logic [DATA_W-1:0] qb_r    [2];
   logic [DATA_W-1:0] qb_i    [2];

   assign idle      = (state == IDLE);
   assign io_bank   = ~active_bank;
   assign swap_busy = ~idle;

   // Enables are gated by idle so DRAIN/SWAP drop all accesses.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         pb_en[k]   = 1'b0;
         pb_we[k]   = 1'b0;
         pb_addr[k] = '0;
         pb_dr[k]   = '0;
         pb_di[k]   = '0;
         if (active_bank == 1'(k)) begin
            pa_en[k]   = cmp_a_en & idle;
            pa_we[k]   = cmp_a_we;
            pa_addr[k] = cmp_a_addr;
            pa_dr[k]   = cmp_a_din_r;
            pa_di[k]   = cmp_a_din_i;
            pb_en[k]   = cmp_b_en & idle;
            pb_we[k]   = cmp_b_we;
            pb_addr[k] = cmp_b_addr;
            pb_dr[k]   = cmp_b_din_r;
            pb_di[k]   = cmp_b_din_i;
         end else begin
            pa_en[k]   = io_en & idle;
            pa_we[k]   = io_we;
            pa_addr[k] = io_addr;
            pa_dr[k]   = io_din_r;
            pa_di[k]   = io_din_i;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      fft_cplx_dpram #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clock    (clock),
         .reset    (reset),
         .a_en     (pa_en[g]),
         .a_we     (pa_we[g]),
         .a_addr   (pa_addr[g]),
         .a_din_r  (pa_dr[g]),
         .a_din_i  (pa_di[g]),
         .a_dout_r (qa_r[g]),
         .a_dout_i (qa_i[g]),
         .b_en     (pb_en[g]),
         .b_we     (pb_we[g]),
         .b_addr   (pb_addr[g]),
         .b_din_r  (pb_dr[g]),
         .b_din_i  (pb_di[g]),
         .b_dout_r (qb_r[g]),
         .b_dout_i (qb_i[g])
      );
   end

   assign cmp_a_dout_r = qa_r[active_bank];
   assign cmp_a_dout_i = qa_i[active_bank];
   assign cmp_b_dout_r = qb_r[active_bank];
   assign cmp_b_dout_i = qb_i[active_bank];
   assign io_dout_r    = qa_r[io_bank];
   assign io_dout_i    = qa_i[io_bank];

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (swap_req) state_n = DRAIN;
         DRAIN:   state_n = SWAP;
         SWAP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         active_bank   <= 1'b0;
         swap_ack      <= 1'b0;
         collision     <= 1'b0;
         io_dout_valid <= 1'b0;
      end else begin
         swap_ack <= (state == SWAP);
         if (state == SWAP)
            active_bank <= ~active_bank;
         collision <= idle & cmp_a_en & cmp_a_we
                    & cmp_b_en & cmp_b_we
                    & (cmp_a_addr == cmp_b_addr);
         io_dout_valid <= idle & io_en & ~io_we;
      end
   end

endmodule
